gate_op_arbiter: RTL and testbench
==================================

// Module: gate_op_arbiter
// PURPOSE
//  Shares one demux-based universal gate unit (NAND/NOR) among N requesters.
//  Arbitrates round-robin and latches the winner's operands and op select.
//  Drives the shared unit, waits a settle time, then captures its output.
//  Returns the result to the winner with a one-cycle done pulse.
//  Sits between requesting control logic and the single shared gate instance.
// PARAMETERS
//  N       4  number of requesters, 2..8
//  SETTLE  1  cycles unit_* is held before unit_y is sampled, 1..15
// PORTS
//  clk      in   1  single clock, rising edge
//  rst      in   1  synchronous, active-high reset
//  req      in   N  per-requester request, level, held until done
//  op       in   N  per-requester op select: 0=NAND, 1=NOR
//  a        in   N  per-requester operand a
//  b        in   N  per-requester operand b
//  gnt      out  N  one-hot grant, high from DRIVE through RESP
//  done     out  N  one-hot, one-cycle completion pulse
//  result   out  1  captured unit_y; valid while done!=0
//  busy     out  1  high when state!=IDLE
//  unit_a   out  1  operand a to shared gate unit
//  unit_b   out  1  operand b to shared gate unit
//  unit_op  out  1  op select to shared gate unit
//  unit_y   in   1  combinational output of shared gate unit
// BEHAVIOUR
//  - Reset: all outputs 0; state=IDLE; rr_ptr=0; settle counter=0; latches=0.
//  - FSM states: IDLE -> DRIVE (SETTLE cycles) -> RESP (1 cycle) -> IDLE.
//  - IDLE with req!=0: winner = first set req bit scanning rr_ptr, rr_ptr+1, ... mod N.
//    - On that edge: latch idx, op[idx], a[idx], b[idx]; go to DRIVE; counter=SETTLE-1.
//  - DRIVE:
//    - gnt[idx]=1; unit_a/unit_b/unit_op = latched values (registered, glitch-free).
//    - Counter decrements each cycle.
//    - On the edge where counter==0: result<=unit_y; go to RESP.
//  - RESP:
//    - done[idx]=1 for exactly one cycle; gnt[idx] stays 1; result held.
//    - On exit: rr_ptr=(idx+1) mod N.
//  - Latency: req seen in IDLE at cycle 0 -> gnt at cycle 1 -> done at cycle SETTLE+1.
//    - Back in IDLE at SETTLE+2; the next grant is no earlier than cycle SETTLE+3.
//  - Operands are latched at grant; changes to a/b/op/req after grant are ignored.
//  - req dropped mid-operation: the operation still completes and done still pulses.
//  - Requester is expected to drop req on the cycle after done; if req is still
//    high, it is treated as a new request, but rr_ptr has moved past it.
//  - Simultaneous requests: exactly one grant; others wait, with no starvation
//    (each requester waits at most N-1 services).
//  - unit_* hold their last value in IDLE; result holds the last captured value;
//    done=0 and gnt=0 outside the states above.
//  - rst in any state: next cycle all outputs 0 and IDLE; no done for the aborted op.
//  - idx and rr_ptr are $clog2(N) bits wide; wrap from N-1 to 0.
// TESTING
//  - Reset: assert rst 2 cycles with req=4'b1111 -> gnt=0, done=0, busy=0, unit_*=0.
//  - Single NAND: req[2]=1, op[2]=0, a[2]=1, b[2]=1, SETTLE=1, gate model attached
//    -> gnt=4'b0100 at cycle 1; done=4'b0100 and result=0 at cycle 2.
//  - NOR case: req[0]=1, op[0]=1, a=b=0 -> result=1 with done[0].
//    - Repeat for all 8 op/a/b combinations vs the NAND/NOR truth table.
//  - Round-robin: req=4'b1111 held continuously -> grant order 0,1,2,3,0.
//    - Each done is SETTLE+2 cycles apart; never two gnt bits high at once.
//  - Operand stability: change a[1] the cycle after gnt[1] rises -> unit_a unchanged,
//    result matches the latched operands.
//  - Reset mid-DRIVE: SETTLE=4, rst at cycle 2 of DRIVE -> no done pulse; IDLE next cycle;
//    a pending req is re-granted from rr_ptr=0.

Source files
------------

// File: rtl/gate_op_arbiter.sv
// Round-robin arbiter sharing one NAND/NOR gate unit among N requesters.
// Latches the winner's operands, holds them on the unit for SETTLE cycles, then captures unit_y.
module gate_op_arbiter #(
    parameter int N      = 4,
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic [N-1:0] op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] gnt,
    output logic [N-1:0] done,
    output logic         result,
    output logic         busy,
    output logic         unit_a,
    output logic         unit_b,
    output logic         unit_op,
    input  logic         unit_y
);

    localparam int W = (N > 1) ? $clog2(N) : 1;
    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   idx_q, idx_d;
    logic [W-1:0]   rr_q, rr_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           op_q, op_d;
    logic           a_q, a_d;
    logic           b_q, b_d;
    logic           res_q, res_d;
    logic [W-1:0]   win;
    logic           found;
    int             j;

    // Rotating priority scan starting at rr_q, wrapping modulo N.
    always_comb begin
        win   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(rr_q) + k;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                found = 1'b1;
                win   = W'(j);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    idx_d   = win;
                    op_d    = op[win];
                    a_d     = a[win];
                    b_d     = b[win];
                    cnt_d   = CNT_INIT;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_q == 4'd0) begin
                    res_d   = unit_y;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                rr_d    = (idx_q == W'(N - 1)) ? '0 : idx_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            res_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    // Unit drive comes straight from flops so it cannot glitch while settling.
    always_comb begin
        gnt  = '0;
        done = '0;
        if (state_q != IDLE) gnt[idx_q] = 1'b1;
        if (state_q == RESP) done[idx_q] = 1'b1;
    end

    assign busy    = (state_q != IDLE);
    assign result  = res_q;
    assign unit_a  = a_q;
    assign unit_b  = b_q;
    assign unit_op = op_q;

endmodule

// File: tb/tb_gate_op_arbiter.sv
// Scoreboard bench for gate_op_arbiter: one instance with SETTLE=1 and one with SETTLE=4,
// each driving its own behavioural NAND/NOR gate model.
module tb_gate_op_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req, op, a, b;

    logic [3:0] gnt1, done1, gnt4, done4;
    logic       res1, busy1, ua1, ub1, uo1, uy1;
    logic       res4, busy4, ua4, ub4, uo4, uy4;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int   idx;
        logic res;
    } exp_t;
    exp_t sb[$];

    assign uy1 = uo1 ? ~(ua1 | ub1) : ~(ua1 & ub1);
    assign uy4 = uo4 ? ~(ua4 | ub4) : ~(ua4 & ub4);

    gate_op_arbiter #(.N(4), .SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .req(req), .op(op), .a(a), .b(b),
        .gnt(gnt1), .done(done1), .result(res1), .busy(busy1),
        .unit_a(ua1), .unit_b(ub1), .unit_op(uo1), .unit_y(uy1)
    );

    gate_op_arbiter #(.N(4), .SETTLE(4)) dut4 (
        .clk(clk), .rst(rst), .req(req), .op(op), .a(a), .b(b),
        .gnt(gnt4), .done(done4), .result(res4), .busy(busy4),
        .unit_a(ua4), .unit_b(ub4), .unit_op(uo4), .unit_y(uy4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic gate_ref(input logic o, input logic x, input logic y);
        return o ? ~(x | y) : ~(x & y);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req = 4'b0000;
        tick;
        tick;
        rst = 1'b0;
    endtask

    // Issue one request, wait (bounded) for done on the chosen instance, compare against scoreboard.
    task automatic run_op(input int r, input logic o, input logic x, input logic y,
                          input bit sel4, input string name);
        exp_t       e;
        logic [3:0] dn, ev;
        logic       rs;
        int         waited;
        tick;
        op[r] = o; a[r] = x; b[r] = y;
        req = 4'b0000;
        req[r] = 1'b1;
        e.idx = r;
        e.res = gate_ref(o, x, y);
        sb.push_back(e);
        waited = 0;
        dn = '0;
        rs = 1'b0;
        while (waited < 30) begin
            @(negedge clk);
            dn = sel4 ? done4 : done1;
            rs = sel4 ? res4 : res1;
            if (dn != 4'b0000) break;
            waited++;
        end
        checks++;
        if (dn == 4'b0000) begin
            failures++;
            $display("FAIL %s_timeout got done=%b required nonzero", name, dn);
            void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            ev = 4'b0001 << e.idx;
            checks++;
            if (dn !== ev) begin
                failures++;
                $display("FAIL %s_done got=%b required=%b", name, dn, ev);
            end
            checks++;
            if (rs !== e.res) begin
                failures++;
                $display("FAIL %s_result got=%b required=%b", name, rs, e.res);
            end
        end
        tick;
        req = 4'b0000;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req = 4'b1111; op = 4'b1111; a = 4'b1111; b = 4'b1111;
        tick;
        tick;
        @(negedge clk);
        checks++;
        if ({gnt1, done1, busy1, ua1, ub1, uo1, res1} !== 13'd0) begin
            failures++;
            $display("FAIL reset_dut1 got=%b required=0", {gnt1, done1, busy1, ua1, ub1, uo1, res1});
        end
        checks++;
        if ({gnt4, done4, busy4, ua4, ub4, uo4, res4} !== 13'd0) begin
            failures++;
            $display("FAIL reset_dut4 got=%b required=0", {gnt4, done4, busy4, ua4, ub4, uo4, res4});
        end
        rst = 1'b0;
        req = 4'b0000;
        tick;
    endtask

    task automatic test_single_nand;
        do_reset;
        tick;
        op[2] = 1'b0; a[2] = 1'b1; b[2] = 1'b1;
        req = 4'b0100;
        @(negedge clk);
        checks++;
        if (gnt1 !== 4'b0000) begin
            failures++;
            $display("FAIL nand_gnt_c0 got=%b required=0000", gnt1);
        end
        tick;
        @(negedge clk);
        checks++;
        if (gnt1 !== 4'b0100 || done1 !== 4'b0000 || busy1 !== 1'b1) begin
            failures++;
            $display("FAIL nand_c1 got gnt=%b done=%b busy=%b required 0100/0000/1", gnt1, done1, busy1);
        end
        tick;
        @(negedge clk);
        checks++;
        if (done1 !== 4'b0100 || res1 !== 1'b0 || gnt1 !== 4'b0100) begin
            failures++;
            $display("FAIL nand_c2 got done=%b res=%b gnt=%b required 0100/0/0100", done1, res1, gnt1);
        end
        tick;
        req = 4'b0000;
        @(negedge clk);
        checks++;
        if (done1 !== 4'b0000 || busy1 !== 1'b0 || res1 !== 1'b0) begin
            failures++;
            $display("FAIL nand_c3 got done=%b busy=%b res=%b required 0000/0/0", done1, busy1, res1);
        end
    endtask

    task automatic test_truth_table;
        logic [2:0] v;
        do_reset;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            run_op((i + 1) % 4, v[2], v[1], v[0], 1'b0, "truth");
        end
    endtask

    task automatic test_round_robin;
        exp_t       e;
        logic [3:0] ev;
        int         ndone, last;
        int         order[5] = '{0, 1, 2, 3, 0};
        do_reset;
        op = 4'b0101; a = 4'b0011; b = 4'b0110;
        for (int i = 0; i < 5; i++) begin
            e.idx = order[i];
            e.res = gate_ref(op[order[i]], a[order[i]], b[order[i]]);
            sb.push_back(e);
        end
        tick;
        req = 4'b1111;
        ndone = 0;
        last = -1;
        for (int c = 0; c < 40 && ndone < 5; c++) begin
            @(negedge clk);
            checks++;
            if ($countones(gnt1) > 1) begin
                failures++;
                $display("FAIL rr_onehot got gnt=%b required at most one bit", gnt1);
            end
            if (done1 != 4'b0000) begin
                e = sb.pop_front();
                ev = 4'b0001 << e.idx;
                checks++;
                if (done1 !== ev) begin
                    failures++;
                    $display("FAIL rr_order got done=%b required=%b", done1, ev);
                end
                checks++;
                if (res1 !== e.res) begin
                    failures++;
                    $display("FAIL rr_result got=%b required=%b", res1, e.res);
                end
                if (last >= 0) begin
                    checks++;
                    if (cyc - last != 3) begin
                        failures++;
                        $display("FAIL rr_spacing got=%0d required=3", cyc - last);
                    end
                end
                last = cyc;
                ndone++;
            end
        end
        checks++;
        if (ndone != 5) begin
            failures++;
            $display("FAIL rr_timeout got=%0d dones required=5", ndone);
        end
        sb.delete();
        tick;
        req = 4'b0000;
    endtask

    task automatic test_operand_stability;
        exp_t e;
        int   c0, waited;
        do_reset;
        tick;
        op[1] = 1'b0; a[1] = 1'b1; b[1] = 1'b1;
        req = 4'b0010;
        e.idx = 1;
        e.res = gate_ref(1'b0, 1'b1, 1'b1);
        sb.push_back(e);
        c0 = cyc;
        tick;
        @(negedge clk);
        checks++;
        if (gnt4 !== 4'b0010) begin
            failures++;
            $display("FAIL stab_gnt got=%b required=0010", gnt4);
        end
        tick;
        a[1] = 1'b0; b[1] = 1'b0; op[1] = 1'b1;
        @(negedge clk);
        checks++;
        if ({ua4, ub4, uo4} !== 3'b110) begin
            failures++;
            $display("FAIL stab_unit got a/b/op=%b required=110", {ua4, ub4, uo4});
        end
        waited = 0;
        while (waited < 20 && done4 == 4'b0000) begin
            @(negedge clk);
            waited++;
        end
        e = sb.pop_front();
        checks++;
        if (done4 !== 4'b0010 || cyc - c0 != 5) begin
            failures++;
            $display("FAIL stab_done got done=%b at cycle %0d required 0010 at cycle 5", done4, cyc - c0);
        end
        checks++;
        if (res4 !== e.res) begin
            failures++;
            $display("FAIL stab_result got=%b required=%b", res4, e.res);
        end
        tick;
        req = 4'b0000;
    endtask

    task automatic test_reset_mid_drive;
        exp_t e;
        int   c0, waited;
        do_reset;
        run_op(2, 1'b0, 1'b1, 1'b0, 1'b1, "pre");
        tick;
        op[3] = 1'b0; a[3] = 1'b1; b[3] = 1'b1;
        op[1] = 1'b1; a[1] = 1'b0; b[1] = 1'b0;
        req = 4'b1010;
        c0 = cyc;
        tick;
        @(negedge clk);
        checks++;
        if (gnt4 !== 4'b1000) begin
            failures++;
            $display("FAIL rmd_first_gnt got=%b required=1000", gnt4);
        end
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({gnt4, done4, busy4} !== 9'd0) begin
            failures++;
            $display("FAIL rmd_after_rst got=%b required=0", {gnt4, done4, busy4});
        end
        e.idx = 1;
        e.res = gate_ref(1'b1, 1'b0, 1'b0);
        sb.push_back(e);
        tick;
        @(negedge clk);
        checks++;
        if (gnt4 !== 4'b0010) begin
            failures++;
            $display("FAIL rmd_regrant got=%b required=0010", gnt4);
        end
        waited = 0;
        while (waited < 20 && done4 == 4'b0000) begin
            @(negedge clk);
            waited++;
        end
        e = sb.pop_front();
        checks++;
        if (done4 !== 4'b0010 || cyc - c0 != 8) begin
            failures++;
            $display("FAIL rmd_done got done=%b at cycle %0d required 0010 at cycle 8", done4, cyc - c0);
        end
        checks++;
        if (res4 !== e.res) begin
            failures++;
            $display("FAIL rmd_result got=%b required=%b", res4, e.res);
        end
        tick;
        req = 4'b0000;
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000; op = 4'b0000; a = 4'b0000; b = 4'b0000;
        test_reset;
        test_single_nand;
        test_truth_table;
        test_round_robin;
        test_operand_stability;
        test_reset_mid_drive;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got no finish required finish");
        $fatal(1);
    end

endmodule
